// File: rtl/dpram_pkg.sv
// Shared sizing for the simple dual-port RAM.
package dpram_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

    // Number of words addressable with an aw-bit address.
    function automatic int depth_of(input int aw);
        return 2 ** aw;
    endfunction

endpackage

// File: rtl/dpram_array.sv
// Storage array: synchronous write, combinational read, no reset so it maps to block RAM.
module dpram_array
    import dpram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = depth_of(ADDR_W);

    // Power-up contents are all zero; rst_n never touches the array.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    // Write port.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dpram.sv
// Simple dual-port RAM, one write port, one read port, 2-cycle registered read.
//
// The read address is registered at edge N and the array output is registered
// into q at edge N+1. The write request is registered alongside the read
// address and committed to the array at edge N+1, in step with the array read.
// A read and write of the same address sampled on the same edge therefore
// returns the old word, while any later read already sees the new one.
module dpram
    import dpram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    input  logic [ADDR_W-1:0] rdaddress,
    output logic [DATA_W-1:0] q
);

    logic [ADDR_W-1:0] rd_addr_r;
    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic [DATA_W-1:0] arr_rdata;

    dpram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock (clock),
        .we    (wr_en_r),
        .waddr (wr_addr_r),
        .wdata (wr_data_r),
        .raddr (rd_addr_r),
        .rdata (arr_rdata)
    );

    // Address/write capture and output register; reset drops in-flight reads and writes.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_r <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            q         <= '0;
        end else begin
            rd_addr_r <= rdaddress;
            wr_en_r   <= wren;
            wr_addr_r <= wraddress;
            wr_data_r <= data;
            q         <= arr_rdata;
        end
    end

endmodule

// File: tb/tb_dpram.sv
// Directed self-checking bench for dpram.
module tb_dpram;

    logic       clock;
    logic       rst_n;
    logic [7:0] data;
    logic [7:0] wraddress;
    logic       wren;
    logic [7:0] rdaddress;
    logic [7:0] q;

    int n_chk;
    int n_fail;

    dpram #(.DATA_W(8), .ADDR_W(8)) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .q         (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wren = 1'b1; wraddress = a; data = d;
        tick();
        wren = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        rdaddress = a;
        tick();
        tick();
        chk(tag, q, exp);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        data = '0; wraddress = '0; wren = 1'b0; rdaddress = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk("reset_q", q, 8'h00);

        // Writes attempted during reset must be dropped.
        wren = 1'b1; wraddress = 8'd30; data = 8'h99; rdaddress = 8'd30;
        tick(); tick(); tick();
        chk("reset_hold_q", q, 8'h00);
        wren = 1'b0;
        rst_n = 1'b1;

        // First read after release: address 30, never written.
        rdaddress = 8'd30;
        tick();
        chk("lat1_q", q, 8'h00);
        tick();
        chk("rd30_zero", q, 8'h00);

        // Back-to-back writes of 255-i to addresses 0..15.
        for (int i = 0; i < 16; i++) begin
            wren = 1'b1; wraddress = 8'(i); data = 8'(255 - i);
            tick();
        end
        wren = 1'b0;

        // Streamed reads, one address per cycle, q two edges behind.
        for (int k = 0; k < 17; k++) begin
            rdaddress = (k < 16) ? 8'(k) : 8'd0;
            tick();
            if (k >= 1) chk($sformatf("stream_%0d", k - 1), q, 8'(256 - k));
        end

        // Read-during-write to the same address returns the old word.
        wr(8'd5, 8'hAA);
        wren = 1'b1; wraddress = 8'd5; data = 8'h55; rdaddress = 8'd5;
        tick();
        wren = 1'b0;
        tick();
        chk("rdw_old", q, 8'hAA);
        tick();
        chk("rdw_new", q, 8'h55);

        // wren=0 leaves memory untouched.
        wr(8'd3, 8'h77);
        wren = 1'b0; wraddress = 8'd3; data = 8'h12;
        tick();
        rd_chk("noen_keep", 8'd3, 8'h77);

        // Top address and bottom address independent.
        wr(8'd255, 8'h3C);
        rd_chk("addr255", 8'd255, 8'h3C);
        rd_chk("addr0_kept", 8'd0, 8'hFF);

        // Write and read of different addresses on the same edge do not interact.
        wren = 1'b1; wraddress = 8'd100; data = 8'h5A; rdaddress = 8'd1;
        tick();
        wren = 1'b0;
        tick();
        chk("diff_rd", q, 8'hFE);
        rd_chk("diff_wr", 8'd100, 8'h5A);

        // Reset in the middle of a read stream clears q at once, keeps contents.
        rdaddress = 8'd1; tick();
        rdaddress = 8'd2; tick();
        chk("pre_rst_q", q, 8'hFE);
        rst_n = 1'b0;
        #1 chk("mid_rst_q", q, 8'h00);
        tick();
        chk("rst_flush_q", q, 8'h00);
        rst_n = 1'b1;
        rd_chk("post_rst_addr0", 8'd0, 8'hFF);
        rd_chk("post_rst_addr2", 8'd2, 8'hFD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        n_fail++;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

endmodule
